// File: rtl/axil_cmd_master_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
package axil_cmd_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_REQ = 3'd1,
        ST_WR_RSP = 3'd2,
        ST_RD_REQ = 3'd3,
        ST_RD_RSP = 3'd4,
        ST_RSP    = 3'd5
    } axil_cmd_state_e;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXIL_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXIL_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_cmd_master_wdt.sv
// Response-wait watchdog: cleared by load_i, counts while en_i, flags after LIMIT cycles.
module axil_cmd_master_wdt #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expire_q, expire_d;

    // Count up to LAST and hold there; expire is high exactly while the count sits at LAST.
    always_comb begin
        cnt_d    = cnt_q;
        expire_d = expire_q;
        if (load_i) begin
            cnt_d    = '0;
            expire_d = 1'b0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d    = cnt_q + CNT_W'(1);
            expire_d = ((cnt_q + CNT_W'(1)) == LAST);
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/axil_cmd_master.sv
// Command/response stream to single AXI4-Lite transactions, one outstanding.
// Optional response timeout: define AXIL_CMD_MASTER_TIMEOUT_EN.
module axil_cmd_master
    import axil_cmd_master_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);

    localparam int unsigned STRB_W = DATA_W / 8;

    if (((DATA_W != 32) && (DATA_W != 64)) || (TIMEOUT_CYC < 2)) begin : g_param_check
        $error("axil_cmd_master: DATA_W must be 32 or 64 and TIMEOUT_CYC >= 2");
    end

    axil_cmd_state_e state_q, state_d;

    logic              write_q, write_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic              bready_q, bready_d, rready_q, rready_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              bstale_q, bstale_d, rstale_q, rstale_d;

    logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, expire;

    assign accept = cmd_valid && cmd_ready_q;
    assign aw_hs  = awvalid_q && awready;
    assign w_hs   = wvalid_q && wready;
    assign b_hs   = bvalid && bready_q;
    assign ar_hs  = arvalid_q && arready;
    assign r_hs   = rvalid && rready_q;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    logic wait_st;
    assign wait_st = (state_q == ST_WR_RSP) || (state_q == ST_RD_RSP);

    axil_cmd_master_wdt #(.LIMIT(TIMEOUT_CYC)) u_wdt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (!wait_st),
        .en_i     (wait_st),
        .expire_o (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a real response wins over a coincident timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = cmd_write ? ST_WR_REQ : ST_RD_REQ;
            ST_WR_REQ: if ((aw_hs || !awvalid_q) && (w_hs || !wvalid_q)) state_d = ST_WR_RSP;
            ST_WR_RSP: if (b_hs || expire) state_d = ST_RSP;
            ST_RD_REQ: if (ar_hs) state_d = ST_RD_RSP;
            ST_RD_RSP: if (r_hs || expire) state_d = ST_RSP;
            ST_RSP:    if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Next values of every registered output, derived from the upcoming state.
    always_comb begin
        write_d       = write_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        arvalid_d     = arvalid_q;
        awaddr_d      = awaddr_q;
        araddr_d      = araddr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        rsp_write_d   = rsp_write_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        bstale_d      = bstale_q;
        rstale_d      = rstale_q;

        if (accept) begin
            write_d = cmd_write;
            if (cmd_write) begin
                awaddr_d  = cmd_addr;
                wdata_d   = cmd_wdata;
                wstrb_d   = cmd_wstrb;
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
            end else begin
                araddr_d  = cmd_addr;
                arvalid_d = 1'b1;
            end
        end
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (ar_hs) arvalid_d = 1'b0;

        // A late response after a timeout is swallowed here.
        if (bstale_q && b_hs) bstale_d = 1'b0;
        if (rstale_q && r_hs) rstale_d = 1'b0;

        if ((state_q != ST_RSP) && (state_d == ST_RSP)) begin
            rsp_write_d = write_q;
            if (write_q) begin
                rsp_rdata_d   = '0;
                rsp_resp_d    = b_hs ? bresp : AXIL_RESP_SLVERR;
                rsp_timeout_d = !b_hs;
                bstale_d      = !b_hs;
            end else begin
                rsp_rdata_d   = r_hs ? rdata : '0;
                rsp_resp_d    = r_hs ? rresp : AXIL_RESP_SLVERR;
                rsp_timeout_d = !r_hs;
                rstale_d      = !r_hs;
            end
        end

        bready_d    = (state_d == ST_WR_RSP) || bstale_d;
        rready_d    = (state_d == ST_RD_RSP) || rstale_d;
        rsp_valid_d = (state_d == ST_RSP);
        cmd_ready_d = (state_d == ST_IDLE) && !bstale_d && !rstale_d;
    end

    // Output and payload registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_q       <= 1'b0;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            awaddr_q      <= '0;
            araddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= AXIL_RESP_OKAY;
            rsp_timeout_q <= 1'b0;
            bstale_q      <= 1'b0;
            rstale_q      <= 1'b0;
        end else begin
            write_q       <= write_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            bready_q      <= bready_d;
            rready_q      <= rready_d;
            awaddr_q      <= awaddr_d;
            araddr_q      <= araddr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_write_q   <= rsp_write_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            bstale_q      <= bstale_d;
            rstale_q      <= rstale_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign awvalid     = awvalid_q;
    assign wvalid      = wvalid_q;
    assign arvalid     = arvalid_q;
    assign bready      = bready_q;
    assign rready      = rready_q;
    assign awaddr      = awaddr_q;
    assign araddr      = araddr_q;
    assign wdata       = wdata_q;
    assign wstrb       = wstrb_q;
    assign awprot      = AXIL_PROT_DEFAULT;
    assign arprot      = AXIL_PROT_DEFAULT;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_write   = rsp_write_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master; the timeout scenario runs when
// AXIL_CMD_MASTER_TIMEOUT_EN is defined (TIMEOUT_CYC = 8).
module tb_axil_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int n_vec = 0;
    int n_err = 0;

    axil_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    endtask

    task automatic present_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = 4'hF;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        step(); step(); step();
        // Reset state
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_awvalid",   32'(awvalid),   0);
        chk("rst_arvalid",   32'(arvalid),   0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_awaddr",    awaddr,         0);
        rst_n = 1'b1;
        step();
        chk("rel_cmd_ready", 32'(cmd_ready), 1);

        // Zero-wait write: cycle 0 accept
        present_cmd(1'b1, 32'h10, 32'hDEADBEEF);
        awready = 1'b1; wready = 1'b1;
        step();                                   // cycle 1
        cmd_valid = 1'b0;
        chk("w0_awvalid", 32'(awvalid), 1);
        chk("w0_wvalid",  32'(wvalid),  1);
        chk("w0_awaddr",  awaddr, 32'h10);
        chk("w0_wdata",   wdata,  32'hDEADBEEF);
        chk("w0_wstrb",   32'(wstrb), 32'hF);
        chk("w0_awprot",  32'(awprot), 0);
        chk("w0_bready1", 32'(bready), 0);
        step();                                   // cycle 2
        awready = 1'b0; wready = 1'b0;
        chk("w0_aw_drop", 32'(awvalid), 0);
        chk("w0_bready2", 32'(bready), 1);
        chk("w0_rspv2",   32'(rsp_valid), 0);
        bvalid = 1'b1; bresp = 2'b00;
        step();                                   // cycle 3
        bvalid = 1'b0;
        chk("w0_rspv3",   32'(rsp_valid), 1);
        chk("w0_resp",    32'(rsp_resp), 0);
        chk("w0_rwrite",  32'(rsp_write), 1);
        chk("w0_rdata",   rsp_rdata, 0);
        chk("w0_bready3", 32'(bready), 0);
        chk("w0_cready3", 32'(cmd_ready), 0);
        rsp_ready = 1'b1;
        step();                                   // cycle 4
        rsp_ready = 1'b0;
        chk("w0_rspv4",   32'(rsp_valid), 0);
        chk("w0_cready4", 32'(cmd_ready), 1);

        // Write with awready delayed, wready immediate
        present_cmd(1'b1, 32'h44, 32'h12345678);
        wready = 1'b1;
        step();                                   // cycle 1: W handshake
        cmd_valid = 1'b0;
        chk("w1_awv1", 32'(awvalid), 1);
        chk("w1_wv1",  32'(wvalid), 1);
        for (int c = 2; c <= 4; c++) begin
            step();
            wready = 1'b0;
            chk("w1_wv_dropped", 32'(wvalid), 0);
            chk("w1_awv_held",   32'(awvalid), 1);
            chk("w1_no_bready",  32'(bready), 0);
            if (c == 4) awready = 1'b1;
        end
        step();                                   // cycle 5: B window
        awready = 1'b0;
        chk("w1_awv5",    32'(awvalid), 0);
        chk("w1_bready5", 32'(bready), 1);
        bvalid = 1'b1; bresp = 2'b11;
        step();                                   // cycle 6: second B must be ignored
        chk("w1_rspv6",   32'(rsp_valid), 1);
        chk("w1_resp6",   32'(rsp_resp), 32'h3);
        chk("w1_bready6", 32'(bready), 0);
        step();
        bvalid = 1'b0;
        chk("w1_bready7", 32'(bready), 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("w1_cready", 32'(cmd_ready), 1);

        // Read with 5-cycle R delay and SLVERR
        present_cmd(1'b0, 32'h20, 32'h0);
        arready = 1'b1;
        step();                                   // cycle 1
        cmd_valid = 1'b0;
        chk("r0_arvalid", 32'(arvalid), 1);
        chk("r0_araddr",  araddr, 32'h20);
        chk("r0_arprot",  32'(arprot), 0);
        chk("r0_awvalid", 32'(awvalid), 0);
        for (int c = 2; c <= 6; c++) begin
            step();
            arready = 1'b0;
            chk("r0_arv_drop", 32'(arvalid), 0);
            chk("r0_rready",   32'(rready), 1);
            chk("r0_wait_rsp", 32'(rsp_valid), 0);
        end
        step();                                   // cycle 7
        rvalid = 1'b1; rdata = 32'hCAFE0001; rresp = 2'b10;
        step();                                   // cycle 8
        rvalid = 1'b0; rdata = 32'h0;
        chk("r0_rspv",   32'(rsp_valid), 1);
        chk("r0_rdata",  rsp_rdata, 32'hCAFE0001);
        chk("r0_resp",   32'(rsp_resp), 32'h2);
        chk("r0_rwrite", 32'(rsp_write), 0);
        chk("r0_rtmo",   32'(rsp_timeout), 0);
        chk("r0_rready", 32'(rready), 0);

        // Response stall: payload holds, nothing new accepted
        present_cmd(1'b1, 32'h99, 32'h55AA55AA);
        for (int c = 0; c < 10; c++) begin
            step();
            chk("st_rspv",   32'(rsp_valid), 1);
            chk("st_rdata",  rsp_rdata, 32'hCAFE0001);
            chk("st_resp",   32'(rsp_resp), 32'h2);
            chk("st_cready", 32'(cmd_ready), 0);
            chk("st_axi",    32'({awvalid, wvalid, arvalid, bready, rready}), 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("st_done_rspv", 32'(rsp_valid), 0);
        chk("st_done_crdy", 32'(cmd_ready), 1);

        // Reset while waiting for B
        present_cmd(1'b1, 32'h30, 32'h0BADF00D);
        awready = 1'b1; wready = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();                                   // WR_RSP
        awready = 1'b0; wready = 1'b0;
        chk("mr_bready", 32'(bready), 1);
        rst_n = 1'b0;
        step();
        chk("mr_valids", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 0);
        chk("mr_cready", 32'(cmd_ready), 0);
        chk("mr_awaddr", awaddr, 0);
        rst_n = 1'b1;
        step();
        chk("mr_cready_rel", 32'(cmd_ready), 1);
        chk("mr_bready_rel", 32'(bready), 0);

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
        // Read timeout after 8 wait cycles, late RVALID absorbed at cycle 20
        present_cmd(1'b0, 32'h40, 32'h0);
        arready = 1'b1;
        step();                                   // cycle 1
        cmd_valid = 1'b0;
        for (int c = 2; c <= 9; c++) begin
            step();
            arready = 1'b0;
            chk("to_wait_rspv", 32'(rsp_valid), 0);
            chk("to_rready",    32'(rready), 1);
        end
        step();                                   // cycle 10
        chk("to_rspv",    32'(rsp_valid), 1);
        chk("to_flag",    32'(rsp_timeout), 1);
        chk("to_resp",    32'(rsp_resp), 32'h2);
        chk("to_rdata",   rsp_rdata, 0);
        chk("to_stale_r", 32'(rready), 1);
        rsp_ready = 1'b1;
        for (int c = 11; c <= 19; c++) begin
            step();
            chk("to_cready_blk", 32'(cmd_ready), 0);
            chk("to_rready_hld", 32'(rready), 1);
            chk("to_rspv_idle",  32'(rsp_valid), 0);
        end
        step();                                   // cycle 20
        rvalid = 1'b1; rdata = 32'h77777777;
        step();                                   // cycle 21
        rvalid = 1'b0;
        chk("to_cready_back", 32'(cmd_ready), 1);
        chk("to_rready_off",  32'(rready), 0);
        chk("to_discarded",   32'(rsp_valid), 0);
        rsp_ready = 1'b0;
`else
        chk("no_tmo_flag", 32'(rsp_timeout), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Guard against a hang anywhere above.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
